// File: rtl/cs_decode_pkg.sv
// cs_decode_pkg
//   Shared definitions for the chip-select region decoder:
//   - state_t      : bus-cycle FSM states (IDLE / WAIT / HOLD)
//   - RST_*        : power-up contents of table entries 0..2
//                    (e0 RAM, e1 I/O, e2 ROM); higher entries come up disabled.
package cs_decode_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int N_RST = 3;

  localparam logic [7:0] RST_BASE [N_RST] = '{8'h00, 8'h60, 8'h80};
  localparam logic [7:0] RST_MASK [N_RST] = '{8'hC0, 8'hE0, 8'h80};
  localparam logic [2:0] RST_WS   [N_RST] = '{3'd0,  3'd2,  3'd1};
  localparam logic       RST_EN   [N_RST] = '{1'b1,  1'b1,  1'b1};

endpackage

// File: rtl/cs_region_decoder_if.sv
// cs_region_decoder_if
//   CPU-side bus and configuration port of the chip-select decoder.
//   master : CPU / configuration side (drives strb, addr, cfg_*)
//   slave  : decoder side (drives cs_n, rdy, hit_idx, busy, miss, abort)
interface cs_region_decoder_if #(
  parameter int ADDR_W  = 16,
  parameter int MATCH_W = 8,
  parameter int N_CS    = 4,
  parameter int WS_W    = 3
);
  localparam int IDX_W = $clog2(N_CS);

  logic               strb;
  logic [ADDR_W-1:0]  addr;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic               cfg_en;
  logic [MATCH_W-1:0] cfg_base;
  logic [MATCH_W-1:0] cfg_mask;
  logic [WS_W-1:0]    cfg_ws;

  logic [N_CS-1:0]    cs_n;
  logic               rdy;
  logic [IDX_W-1:0]   hit_idx;
  logic               busy;
  logic               miss;
  logic               abort;

  modport master (
    output strb, addr, cfg_we, cfg_idx, cfg_en, cfg_base, cfg_mask, cfg_ws,
    input  cs_n, rdy, hit_idx, busy, miss, abort
  );

  modport slave (
    input  strb, addr, cfg_we, cfg_idx, cfg_en, cfg_base, cfg_mask, cfg_ws,
    output cs_n, rdy, hit_idx, busy, miss, abort
  );
endinterface

// File: rtl/cs_region_match.sv
// cs_region_match
//   One programmable decode-table entry plus its address comparator.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     cfg_we/cfg_idx  table write strobe and target index (accepted when cfg_idx == IDX)
//     cfg_en/base/mask/ws  new entry contents
//     addr_hi         upper address bits being decoded
//     hit             entry enabled and addr_hi matches base under mask
//     ws              wait-state count of this entry
module cs_region_match
  import cs_decode_pkg::*;
#(
  parameter int MATCH_W = 8,
  parameter int WS_W    = 3,
  parameter int IDX_W   = 2,
  parameter int IDX     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [MATCH_W-1:0] cfg_base,
  input  logic [MATCH_W-1:0] cfg_mask,
  input  logic [WS_W-1:0]    cfg_ws,
  input  logic [MATCH_W-1:0] addr_hi,
  output logic               hit,
  output logic [WS_W-1:0]    ws
);
  // Entries beyond the built-in ones power up disabled and zeroed.
  localparam bool_dummy = 0;
  localparam logic               RST_E = (IDX < N_RST) ? RST_EN[IDX % N_RST] : 1'b0;
  localparam logic [MATCH_W-1:0] RST_B = (IDX < N_RST) ? MATCH_W'(RST_BASE[IDX % N_RST]) : '0;
  localparam logic [MATCH_W-1:0] RST_M = (IDX < N_RST) ? MATCH_W'(RST_MASK[IDX % N_RST]) : '0;
  localparam logic [WS_W-1:0]    RST_W = (IDX < N_RST) ? WS_W'(RST_WS[IDX % N_RST]) : '0;

  logic               en_reg;
  logic [MATCH_W-1:0] base_reg;
  logic [MATCH_W-1:0] mask_reg;
  logic [WS_W-1:0]    ws_reg;

  logic sel;
  assign sel = cfg_we && (cfg_idx == IDX_W'(IDX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg   <= RST_E;
      base_reg <= RST_B;
      mask_reg <= RST_M;
      ws_reg   <= RST_W;
    end else if (sel) begin
      en_reg   <= cfg_en;
      base_reg <= cfg_base;
      mask_reg <= cfg_mask;
      ws_reg   <= cfg_ws;
    end
  end

  assign hit = en_reg && (((addr_hi ^ base_reg) & mask_reg) == '0);
  assign ws  = ws_reg;
endmodule

// File: rtl/cs_region_decoder.sv
// cs_region_decoder
//   Decodes the CPU address against N_CS programmable base/mask regions,
//   drives one-hot active-low chip selects, stretches the cycle with RDY
//   for per-region wait states and flags unmapped accesses.
//   Ports:
//     clk  system clock
//     rst  asynchronous reset, active-high
//     bus  cs_region_decoder_if.slave: strb/addr/cfg_* in;
//          cs_n/rdy/hit_idx/busy/miss/abort out (all registered)
module cs_region_decoder
  import cs_decode_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MATCH_W = 8,
  parameter int N_CS    = 4,
  parameter int WS_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  cs_region_decoder_if.slave bus
);
  localparam int IDX_W = $clog2(N_CS);

  logic [MATCH_W-1:0] addr_hi;
  assign addr_hi = bus.addr[ADDR_W-1 -: MATCH_W];
  // Low address bits take no part in decoding.
  wire unused_addr = &{1'b0, bus.addr[ADDR_W-MATCH_W-1:0]};

  logic [N_CS-1:0] hit_vec;
  logic [WS_W-1:0] ws_vec [N_CS];

  generate
    for (genvar gi = 0; gi < N_CS; gi++) begin : g_entry
      cs_region_match #(
        .MATCH_W(MATCH_W), .WS_W(WS_W), .IDX_W(IDX_W), .IDX(gi)
      ) u_match (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (bus.cfg_we),
        .cfg_idx (bus.cfg_idx),
        .cfg_en  (bus.cfg_en),
        .cfg_base(bus.cfg_base),
        .cfg_mask(bus.cfg_mask),
        .cfg_ws  (bus.cfg_ws),
        .addr_hi (addr_hi),
        .hit     (hit_vec[gi]),
        .ws      (ws_vec[gi])
      );
    end
  endgenerate

  // Priority encoder: scanning downwards leaves the lowest hitting index.
  logic             hit_any;
  logic [IDX_W-1:0] sel_idx;
  logic [WS_W-1:0]  sel_ws;
  logic [N_CS-1:0]  sel_onehot;

  always_comb begin
    sel_idx    = '0;
    sel_ws     = '0;
    sel_onehot = '0;
    hit_any    = |hit_vec;
    for (int i = N_CS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_idx = IDX_W'(i);
        sel_ws  = ws_vec[i];
      end
    end
    sel_onehot[sel_idx] = hit_any;
  end

  // Strobe edge detect
  logic strb_q;
  logic rise;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) strb_q <= 1'b0;
    else     strb_q <= bus.strb;
  end
  assign rise = bus.strb && !strb_q;

  // FSM and output registers
  state_t           state_reg,   state_next;
  logic [WS_W-1:0]  cnt_reg,     cnt_next;
  logic [N_CS-1:0]  cs_n_reg,    cs_n_next;
  logic             rdy_reg,     rdy_next;
  logic             busy_reg,    busy_next;
  logic             miss_reg,    miss_next;
  logic             abort_reg,   abort_next;
  logic [IDX_W-1:0] hit_idx_reg, hit_idx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      cs_n_reg    <= '1;
      rdy_reg     <= 1'b1;
      busy_reg    <= 1'b0;
      miss_reg    <= 1'b0;
      abort_reg   <= 1'b0;
      hit_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cs_n_reg    <= cs_n_next;
      rdy_reg     <= rdy_next;
      busy_reg    <= busy_next;
      miss_reg    <= miss_next;
      abort_reg   <= abort_next;
      hit_idx_reg <= hit_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cs_n_next    = cs_n_reg;
    rdy_next     = rdy_reg;
    busy_next    = busy_reg;
    miss_next    = 1'b0;
    hit_idx_next = hit_idx_reg;
    // A table write clears a pending abort; a new abort this cycle still wins.
    abort_next   = bus.cfg_we ? 1'b0 : abort_reg;

    unique case (state_reg)
      IDLE: begin
        if (rise) begin
          busy_next = 1'b1;
          if (hit_any) begin
            cs_n_next    = ~sel_onehot;
            hit_idx_next = sel_idx;
            if (sel_ws != '0) begin
              rdy_next   = 1'b0;
              cnt_next   = sel_ws;
              state_next = WAIT;
            end else begin
              state_next = HOLD;
            end
          end else begin
            miss_next    = 1'b1;
            hit_idx_next = '0;
            state_next   = HOLD;
          end
        end
      end
      WAIT: begin
        if (!bus.strb) begin
          cs_n_next  = '1;
          rdy_next   = 1'b1;
          busy_next  = 1'b0;
          abort_next = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == WS_W'(1)) begin
          rdy_next   = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg - WS_W'(1);
        end
      end
      HOLD: begin
        if (!bus.strb) begin
          cs_n_next  = '1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cs_n    = cs_n_reg;
  assign bus.rdy     = rdy_reg;
  assign bus.busy    = busy_reg;
  assign bus.miss    = miss_reg;
  assign bus.abort   = abort_reg;
  assign bus.hit_idx = hit_idx_reg;
endmodule

// File: tb/tb_cs_region_decoder.sv
module tb_cs_region_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cs_region_decoder_if #(.ADDR_W(16), .MATCH_W(8), .N_CS(4), .WS_W(3)) bus();

  cs_region_decoder #(.ADDR_W(16), .MATCH_W(8), .N_CS(4), .WS_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.strb     = 1'b0;
    bus.addr     = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_idx  = '0;
    bus.cfg_en   = 1'b0;
    bus.cfg_base = '0;
    bus.cfg_mask = '0;
    bus.cfg_ws   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strb_up(input logic [15:0] a);
    @(negedge clk);
    bus.addr = a;
    bus.strb = 1'b1;
    tick();
    $display("[TB] access addr=%h cs_n=%b rdy=%b busy=%b miss=%b idx=%0d",
             a, bus.cs_n, bus.rdy, bus.busy, bus.miss, bus.hit_idx);
  endtask

  task automatic strb_down();
    @(negedge clk);
    bus.strb = 1'b0;
    tick();
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic en, input logic [7:0] base,
                           input logic [7:0] mask, input logic [2:0] ws);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = idx;
    bus.cfg_en   = en;
    bus.cfg_base = base;
    bus.cfg_mask = mask;
    bus.cfg_ws   = ws;
    tick();
    bus.cfg_we = 1'b0;
    $display("[TB] cfg e%0d en=%b base=%h mask=%h ws=%0d", idx, en, base, mask, ws);
  endtask

  // Samples rdy now and on the following n-1 clocks, counting low samples.
  task automatic sample_rdy(input int n, output int lows);
    lows = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      if (bus.rdy === 1'b0) lows++;
    end
  endtask

  task automatic test_reset();
    int lows;
    rst = 1'b1;
    bus.strb = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({bus.cs_n, bus.rdy, bus.busy, bus.miss, bus.abort, bus.hit_idx} !== {4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got cs_n=%b rdy=%b busy=%b miss=%b abort=%b idx=%0d, want 1111 1 0 0 0 0",
               bus.cs_n, bus.rdy, bus.busy, bus.miss, bus.abort, bus.hit_idx);
    end
    do_reset();
    strb_up(16'h1234);
    n_tests++;
    if (bus.cs_n !== 4'b1110 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ram_select: got cs_n=%b busy=%b, want 1110 1", bus.cs_n, bus.busy);
    end
    sample_rdy(4, lows);
    n_tests++;
    if (lows !== 0) begin
      n_fail++;
      $display("FAIL ram_no_wait: got %0d rdy-low clks, want 0", lows);
    end
    strb_down();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.cs_n !== 4'hF) begin
      n_fail++;
      $display("FAIL ram_release: got busy=%b cs_n=%b, want 0 1111", bus.busy, bus.cs_n);
    end
  endtask

  task automatic test_wait_states();
    int lows;
    strb_up(16'h6000);
    n_tests++;
    if (bus.cs_n !== 4'b1101 || bus.hit_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL io_select: got cs_n=%b idx=%0d, want 1101 1", bus.cs_n, bus.hit_idx);
    end
    sample_rdy(6, lows);
    n_tests++;
    if (lows !== 2 || bus.rdy !== 1'b1 || bus.cs_n !== 4'b1101) begin
      n_fail++;
      $display("FAIL io_wait: got lows=%0d rdy=%b cs_n=%b, want 2 1 1101", lows, bus.rdy, bus.cs_n);
    end
    strb_down();
    strb_up(16'hFFFC);
    n_tests++;
    if (bus.cs_n !== 4'b1011) begin
      n_fail++;
      $display("FAIL rom_select: got cs_n=%b, want 1011", bus.cs_n);
    end
    sample_rdy(4, lows);
    n_tests++;
    if (lows !== 1 || bus.rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rom_wait: got lows=%0d rdy=%b, want 1 1", lows, bus.rdy);
    end
    strb_down();
  endtask

  task automatic test_miss_priority();
    logic [15:0] addrs [4];
    addrs = '{16'h4000, 16'h6000, 16'hFFFC, 16'h1234};
    strb_up(16'h4000);
    n_tests++;
    if (bus.miss !== 1'b1 || bus.cs_n !== 4'hF || bus.busy !== 1'b1 || bus.rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_flag: got miss=%b cs_n=%b busy=%b rdy=%b, want 1 1111 1 1",
               bus.miss, bus.cs_n, bus.busy, bus.rdy);
    end
    tick();
    n_tests++;
    if (bus.miss !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_pulse: got miss=%b busy=%b, want 0 1", bus.miss, bus.busy);
    end
    strb_down();
    cfg_write(2'd3, 1'b1, 8'h40, 8'hC0, 3'd0);
    strb_up(16'h4000);
    n_tests++;
    if (bus.cs_n !== 4'b0111 || bus.miss !== 1'b0 || bus.hit_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL e3_select: got cs_n=%b miss=%b idx=%0d, want 0111 0 3", bus.cs_n, bus.miss, bus.hit_idx);
    end
    strb_down();
    cfg_write(2'd0, 1'b1, 8'h00, 8'h00, 3'd0);
    for (int k = 0; k < 4; k++) begin
      strb_up(addrs[k]);
      n_tests++;
      if (bus.cs_n !== 4'b1110 || bus.rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL priority_e0 addr=%h: got cs_n=%b rdy=%b, want 1110 1", addrs[k], bus.cs_n, bus.rdy);
      end
      strb_down();
    end
  endtask

  task automatic test_abort();
    do_reset();
    cfg_write(2'd1, 1'b1, 8'h60, 8'hE0, 3'd7);
    strb_up(16'h6000);
    tick();
    tick();
    n_tests++;
    if (bus.rdy !== 1'b0 || bus.cs_n !== 4'b1101) begin
      n_fail++;
      $display("FAIL abort_waiting: got rdy=%b cs_n=%b, want 0 1101", bus.rdy, bus.cs_n);
    end
    strb_down();
    n_tests++;
    if (bus.cs_n !== 4'hF || bus.rdy !== 1'b1 || bus.abort !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_set: got cs_n=%b rdy=%b abort=%b busy=%b, want 1111 1 1 0",
               bus.cs_n, bus.rdy, bus.abort, bus.busy);
    end
    tick();
    tick();
    n_tests++;
    if (bus.abort !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_sticky: got abort=%b, want 1", bus.abort);
    end
    cfg_write(2'd3, 1'b0, 8'h00, 8'h00, 3'd0);
    n_tests++;
    if (bus.abort !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: got abort=%b, want 0", bus.abort);
    end
  endtask

  task automatic test_config_midcycle();
    do_reset();
    strb_up(16'h6000);
    tick();
    tick();
    n_tests++;
    if (bus.rdy !== 1'b1 || bus.cs_n !== 4'b1101) begin
      n_fail++;
      $display("FAIL hold_reached: got rdy=%b cs_n=%b, want 1 1101", bus.rdy, bus.cs_n);
    end
    cfg_write(2'd1, 1'b0, 8'h60, 8'h00, 3'd2);
    tick();
    n_tests++;
    if (bus.cs_n !== 4'b1101 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_midcycle_hold: got cs_n=%b busy=%b, want 1101 1", bus.cs_n, bus.busy);
    end
    strb_down();
    strb_up(16'h6000);
    n_tests++;
    if (bus.miss !== 1'b1 || bus.cs_n !== 4'hF) begin
      n_fail++;
      $display("FAIL cfg_next_miss: got miss=%b cs_n=%b, want 1 1111", bus.miss, bus.cs_n);
    end
    strb_down();
  endtask

  task automatic test_async_reset();
    int lows;
    do_reset();
    cfg_write(2'd1, 1'b1, 8'h60, 8'hE0, 3'd5);
    cfg_write(2'd3, 1'b1, 8'h40, 8'hC0, 3'd0);
    strb_up(16'h6000);
    tick();
    n_tests++;
    if (bus.rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_rst_wait: got rdy=%b, want 0", bus.rdy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.cs_n, bus.rdy, bus.busy, bus.miss, bus.abort, bus.hit_idx} !== {4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL async_rst_outputs: got cs_n=%b rdy=%b busy=%b miss=%b abort=%b idx=%0d, want 1111 1 0 0 0 0",
               bus.cs_n, bus.rdy, bus.busy, bus.miss, bus.abort, bus.hit_idx);
    end
    bus.strb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    strb_up(16'h6000);
    sample_rdy(6, lows);
    n_tests++;
    if (lows !== 2) begin
      n_fail++;
      $display("FAIL table_default_ws: got %0d rdy-low clks, want 2", lows);
    end
    strb_down();
    strb_up(16'h4000);
    n_tests++;
    if (bus.miss !== 1'b1 || bus.cs_n !== 4'hF) begin
      n_fail++;
      $display("FAIL table_default_e3: got miss=%b cs_n=%b, want 1 1111", bus.miss, bus.cs_n);
    end
    strb_down();
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_miss_priority();
    test_abort();
    test_config_midcycle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound, want completion");
    $fatal(1);
  end
endmodule
